// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI burst RAM responder.
package axi_ram_pkg;

   localparam int unsigned CNT_W = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   // Burst length field limited to the largest supported beats-1.
   function automatic logic [CNT_W-1:0] clamp_len(input logic [7:0] len,
                                                  input int unsigned max_len);
      if (32'(len) > max_len) return CNT_W'(max_len);
      return CNT_W'(len);
   endfunction

endpackage

// File: rtl/axi_ram_mem.sv
// Word-organised RAM: one registered read port, one byte-enabled write port.
// A read and write to the same word on the same edge returns the old data.
module axi_ram_mem #(
   parameter int unsigned AW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   input  logic [3:0]    wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rd_data_d;
   logic [31:0] rd_data_q;

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) rd_data_d = mem_q[rd_addr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end

   // Array contents survive reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_en[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI INCR burst RAM responder with independent read and write FSMs.
// Define AXI_RAM_RDELAY_EN to insert RD_DELAY wait cycles before each read burst.
module axi_ram_slave
   import axi_ram_pkg::*;
#(
   parameter int unsigned MEM_AW   = 12,
   parameter int unsigned MAX_LEN  = 15,
   parameter int unsigned RD_DELAY = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] araddr,
   input  logic [7:0]  arlen,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic [7:0]  awlen,
   input  logic [2:0]  awsize,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

`ifdef AXI_RAM_RDELAY_EN
   localparam bit RDELAY_EN = 1'b1;
`else
   localparam bit RDELAY_EN = 1'b0;
`endif
   localparam bit              USE_WAIT  = RDELAY_EN && (RD_DELAY != 0);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_DELAY > 0) ? RD_DELAY - 1 : 0);

   rd_state_e         rstate_q, rstate_d;
   logic [MEM_AW-1:0] rindex_q, rindex_d;
   logic [CNT_W-1:0]  rlen_q, rlen_d, rcnt_q, rcnt_d, rwait_q, rwait_d;
   logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;

   wr_state_e         wstate_q, wstate_d;
   logic [MEM_AW-1:0] windex_q, windex_d;
   logic [CNT_W-1:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic              werr_q, werr_d, awready_q, awready_d, wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;

   logic              mem_ren_c;
   logic [MEM_AW-1:0] mem_raddr_c;
   logic [3:0]        mem_we_c;
   logic [31:0]       mem_rdata;

   logic [MEM_AW-1:0] ar_index_c, aw_index_c;
   logic [CNT_W-1:0]  ar_len_c, aw_len_c;
   logic              wr_last_c, werr_c;
   logic              unused_c;

   assign ar_index_c = araddr[MEM_AW+1:2];
   assign aw_index_c = awaddr[MEM_AW+1:2];
   assign ar_len_c   = clamp_len(arlen, MAX_LEN);
   assign aw_len_c   = clamp_len(awlen, MAX_LEN);
   assign unused_c   = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

   axi_ram_mem #(.AW(MEM_AW)) u_mem (
      .clk     (clk),
      .rst_n   (resetn),
      .rd_en   (mem_ren_c),
      .rd_addr (mem_raddr_c),
      .rd_data (mem_rdata),
      .wr_en   (mem_we_c),
      .wr_addr (windex_q),
      .wr_data (wdata)
   );

   // Read FSM: each accepted beat prefetches the next word so beats stream back to back.
   always_comb begin
      rstate_d    = rstate_q;
      rindex_d    = rindex_q;
      rlen_d      = rlen_q;
      rcnt_d      = rcnt_q;
      rwait_d     = rwait_q;
      arready_d   = arready_q;
      rvalid_d    = rvalid_q;
      rlast_d     = rlast_q;
      mem_ren_c   = 1'b0;
      mem_raddr_c = rindex_q;
      case (rstate_q)
         R_IDLE: begin
            if (arvalid && arready_q) begin
               rindex_d  = ar_index_c;
               rlen_d    = ar_len_c;
               rcnt_d    = '0;
               rwait_d   = '0;
               arready_d = 1'b0;
               if (USE_WAIT) begin
                  rstate_d = R_WAIT;
               end else begin
                  mem_ren_c   = 1'b1;
                  mem_raddr_c = ar_index_c;
                  rvalid_d    = 1'b1;
                  rlast_d     = (ar_len_c == '0);
                  rstate_d    = R_DATA;
               end
            end
         end
         R_WAIT: begin
            if (rwait_q == WAIT_LAST) begin
               mem_ren_c = 1'b1;
               rvalid_d  = 1'b1;
               rlast_d   = (rlen_q == '0);
               rstate_d  = R_DATA;
            end else begin
               rwait_d = rwait_q + CNT_W'(1);
            end
         end
         R_DATA: begin
            if (rready) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  arready_d = 1'b1;
                  rstate_d  = R_IDLE;
               end else begin
                  rindex_d    = rindex_q + MEM_AW'(1);
                  rcnt_d      = rcnt_q + CNT_W'(1);
                  mem_ren_c   = 1'b1;
                  mem_raddr_c = rindex_q + MEM_AW'(1);
                  rlast_d     = ((rcnt_q + CNT_W'(1)) == rlen_q);
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rstate_q  <= R_IDLE;
         rindex_q  <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rwait_q   <= '0;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
      end else begin
         rstate_q  <= rstate_d;
         rindex_q  <= rindex_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
         rwait_q   <= rwait_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
      end
   end

   // Write FSM: length is fixed by AW; wlast only feeds the error flag.
   always_comb begin
      wstate_d  = wstate_q;
      windex_d  = windex_q;
      wlen_d    = wlen_q;
      wcnt_d    = wcnt_q;
      werr_d    = werr_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      mem_we_c  = '0;
      wr_last_c = (wcnt_q == wlen_q);
      werr_c    = werr_q | (wlast != wr_last_c);
      case (wstate_q)
         W_IDLE: begin
            if (awvalid && awready_q) begin
               windex_d  = aw_index_c;
               wlen_d    = aw_len_c;
               wcnt_d    = '0;
               werr_d    = (awsize < 3'd2) && (aw_len_c != '0);
               awready_d = 1'b0;
               wready_d  = 1'b1;
               wstate_d  = W_DATA;
            end
         end
         W_DATA: begin
            if (wvalid && wready_q) begin
               mem_we_c = wstrb;
               werr_d   = werr_c;
               if (wr_last_c) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bresp_d  = werr_c ? RESP_SLVERR : RESP_OKAY;
                  wstate_d = W_RESP;
               end else begin
                  windex_d = windex_q + MEM_AW'(1);
                  wcnt_d   = wcnt_q + CNT_W'(1);
               end
            end
         end
         W_RESP: begin
            if (bready) begin
               bvalid_d  = 1'b0;
               bresp_d   = RESP_OKAY;
               awready_d = 1'b1;
               wstate_d  = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wstate_q  <= W_IDLE;
         windex_q  <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         werr_q    <= 1'b0;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
      end else begin
         wstate_q  <= wstate_d;
         windex_q  <= windex_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         werr_q    <= werr_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
      end
   end

   assign arready = arready_q;
   assign rdata   = mem_rdata;
   assign rresp   = RESP_OKAY;
   assign rlast   = rlast_q;
   assign rvalid  = rvalid_q;
   assign awready = awready_q;
   assign wready  = wready_q;
   assign bresp   = bresp_q;
   assign bvalid  = bvalid_q;

endmodule
